surf_cmd_receiver: RTL
======================

Name: surf_cmd_receiver

Overview:
- Deserialises the serial trigger/command line (cmd_i) into event records.
- Each accepted frame produces a one-cycle write strobe plus a 32-bit event ID, a 2-bit LAB buffer select and a parity-OK flag.
- These outputs feed the readout/register block's event FIFO inputs (event_done_in, event_id_i, lab_sel_i, FIFO bit 34).
- Also issues per-buffer digitize strobes to the LAB controllers, and counts framing errors and dropped frames.

Parameters:
- CLKS_PER_BIT, 4, clk_i cycles per serial bit; must be an even number and at least 2.
- SAMPLE_PT, 2, cycle within a bit period at which the bit is sampled; range 1..CLKS_PER_BIT-1.

Ports:
- clk_i  in  1  system clock (33 MHz domain).
- nrst_i  in  1  synchronous reset, active low.
- cmd_i  in  1  serial command line; asynchronous to clk_i; idles low.
- fifo_full_i  in  1  downstream event FIFO full.
- event_wr_o  out  1  one-cycle strobe: event record valid.
- event_id_o  out  32  event ID; held until the next accepted frame.
- event_buffer_o  out  2  LAB buffer select; held until the next accepted frame.
- event_id_ok_o  out  1  parity of the last accepted frame was correct.
- digitize_o  out  4  one-hot digitize strobe, one cycle, coincident with event_wr_o.
- frame_err_o  out  8  saturating count of stop-bit errors.
- drop_cnt_o  out  8  saturating count of frames dropped because the FIFO was full.
- busy_o  out  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (nrst_i low at a clock edge): state goes to IDLE, and every output goes to 0. Synchroniser flops are cleared. Reset overrides everything, including a frame in progress, which is discarded with no strobe.
- Input conditioning: cmd_i passes through a 2-flop synchroniser; the result is cmd_s. A start edge is cmd_s = 1 while the previous cmd_s = 0.
- Frame format, 37 bits, MSB first:
  - start bit = 1
  - buffer[1:0]
  - id[31:0]
  - parity bit, making the count of 1s across buffer+id+parity even
  - stop bit = 0
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. It restarts at 0 on the cycle the start edge is detected; that cycle is count 0 of the start bit. A bit is sampled when the count equals SAMPLE_PT.
- State machine:
  - IDLE: on a start edge, go to START and clear the bit index.
  - START: at the sample point, cmd_s = 1 goes to DATA; cmd_s = 0 (glitch) returns to IDLE with no count incremented.
  - DATA: at each sample point, shift cmd_s into a 35-bit shift register and increment the bit index. After the 35th sample, go to STOP.
  - STOP: at the sample point:
    - cmd_s = 0 goes to EMIT.
    - cmd_s = 1: frame_err_o increments (saturating at 255), the frame is discarded, and the block goes to REARM.
  - EMIT: one cycle.
    - If fifo_full_i = 0: event_id_o, event_buffer_o and event_id_ok_o load; event_wr_o = 1; digitize_o = 1 << buffer.
    - If fifo_full_i = 1: drop_cnt_o increments (saturating), there is no strobe and the held outputs are unchanged.
    - In both cases, go to REARM.
  - REARM: wait until cmd_s = 0, then go to IDLE. This prevents a line stuck high from producing back-to-back frames.
- Latency: event_wr_o is asserted on the clock after the stop-bit sample edge. Total from the start edge on cmd_s is 36·CLKS_PER_BIT + SAMPLE_PT + 1 cycles.
- Parity: event_id_ok_o = ~^{buffer, id, parity}. Frames with bad parity are still written, with ok = 0; downstream flags them.
- Sampling of fifo_full_i: only in EMIT. A full condition arising mid-frame has no effect until EMIT.
- Counters: 8-bit, saturate at 8'hFF and never wrap. They are cleared only by reset.
- Start edges seen while not in IDLE are ignored.
- Minimum frame spacing: 37 bit periods plus one low bit period.

Test Plan:
1. Reset, then a frame with buffer = 2'b10, id = 32'hDEADBEEF, correct parity, CLKS_PER_BIT = 4 -> event_wr_o one cycle at the specified latency; event_id_o = DEADBEEF; event_buffer_o = 2; event_id_ok_o = 1; digitize_o = 4'b0100; counters 0.
2. The same frame with the parity bit inverted -> strobe fires; event_id_ok_o = 0; id and buffer as sent.
3. Stop bit driven 1, then the line held high for 10 bit periods -> no strobe; frame_err_o = 1; no new frame until the line returns low; a following good frame (id = 32'h00000001, buffer 0) is accepted with digitize_o = 4'b0001.
4. fifo_full_i = 1 during EMIT of a frame with id = 32'h12345678 -> no strobe; drop_cnt_o = 1; event_id_o retains its previous value. The next frame with full = 0 is accepted.
5. A one-clock-wide high glitch on cmd_i (shorter than SAMPLE_PT) -> returns to IDLE; no counters change; busy_o pulses; no strobe.
6. nrst_i pulsed low mid-DATA (bit index 20) -> all outputs 0 next cycle; no strobe. A good frame sent after reset is received correctly. 300 forced stop errors -> frame_err_o saturates at 255.

Source files
------------

// File: rtl/surf_cmd_receiver_if.sv
// Signal bundle between the serial command receiver and its environment.
// master drives the serial line and FIFO-full status; slave is the receiver.
// Purely structural: no logic, no latency, no flow control of its own.
interface surf_cmd_receiver_if;
  logic        cmd_i;
  logic        fifo_full_i;
  logic        event_wr_o;
  logic [31:0] event_id_o;
  logic [1:0]  event_buffer_o;
  logic        event_id_ok_o;
  logic [3:0]  digitize_o;
  logic [7:0]  frame_err_o;
  logic [7:0]  drop_cnt_o;
  logic        busy_o;

  modport master (
    output cmd_i,
    output fifo_full_i,
    input  event_wr_o,
    input  event_id_o,
    input  event_buffer_o,
    input  event_id_ok_o,
    input  digitize_o,
    input  frame_err_o,
    input  drop_cnt_o,
    input  busy_o
  );

  modport slave (
    input  cmd_i,
    input  fifo_full_i,
    output event_wr_o,
    output event_id_o,
    output event_buffer_o,
    output event_id_ok_o,
    output digitize_o,
    output frame_err_o,
    output drop_cnt_o,
    output busy_o
  );
endinterface

// File: rtl/surf_cmd_receiver.sv
// Deserialises the 37-bit trigger/command frame into an event record + digitize strobe.
// Latency: event_wr_o fires 36*CLKS_PER_BIT+SAMPLE_PT+1 cycles after the start edge on cmd_s.
// Backpressure: fifo_full_i is looked at only in EMIT; a full FIFO drops the frame and counts it.
module surf_cmd_receiver #(
  parameter int CLKS_PER_BIT = 4,
  parameter int SAMPLE_PT    = 2
) (
  input logic               clk_i,
  input logic               nrst_i,
  surf_cmd_receiver_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(SAMPLE_PT);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  // Index value of the final payload bit (35 payload bits: buffer, id, parity)
  localparam logic [5:0]    LAST_IDX  = 6'd34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_EMIT,
    ST_REARM
  } state_t;

  state_t state, state_nxt;

  logic          cmd_meta;
  logic          cmd_s;
  logic          cmd_s_d;
  logic          start_edge;
  logic          sample;
  logic [CW-1:0] bit_cnt;
  logic [5:0]    bit_idx;
  logic [34:0]   shreg;

  logic [31:0]   id_q;
  logic [1:0]    buf_q;
  logic          ok_q;
  logic [7:0]    frame_err_q;
  logic [7:0]    drop_cnt_q;

  logic          emit_acc;
  logic          emit_drop;
  logic          stop_err;

  // Payload fields as they sit in the shift register after the last data sample
  logic [1:0]    sr_buf;
  logic [31:0]   sr_id;
  logic          sr_ok;

  assign sr_buf     = shreg[34:33];
  assign sr_id      = shreg[32:1];
  assign sr_ok      = ~^shreg;
  assign start_edge = cmd_s & ~cmd_s_d;
  assign sample     = (bit_cnt == SAMPLE_AT);

  // Two-flop synchroniser for the asynchronous line, plus one delayed copy for edge detect
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      cmd_meta <= 1'b0;
      cmd_s    <= 1'b0;
      cmd_s_d  <= 1'b0;
    end else begin
      cmd_meta <= bus.cmd_i;
      cmd_s    <= cmd_meta;
      cmd_s_d  <= cmd_s;
    end
  end

  // Bit timer: the start-edge cycle is count 0, so the following cycle is count 1
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      bit_cnt <= '0;
    end else if (state == ST_IDLE) begin
      bit_cnt <= start_edge ? CW'(1) : '0;
    end else if (bit_cnt == LAST_CNT) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start edges outside IDLE are simply not looked at
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_edge) state_nxt = ST_START;
      ST_START: if (sample) state_nxt = cmd_s ? ST_DATA : ST_IDLE;
      ST_DATA:  if (sample && (bit_idx == LAST_IDX)) state_nxt = ST_STOP;
      ST_STOP:  if (sample) state_nxt = cmd_s ? ST_REARM : ST_EMIT;
      ST_EMIT:  state_nxt = ST_REARM;
      // Holding here until the line drops stops a stuck-high line re-triggering
      ST_REARM: if (!cmd_s) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the current state
  always_comb begin
    emit_acc  = 1'b0;
    emit_drop = 1'b0;
    stop_err  = 1'b0;
    case (state)
      ST_STOP: stop_err  = sample & cmd_s;
      ST_EMIT: begin
        emit_acc  = ~bus.fifo_full_i;
        emit_drop =  bus.fifo_full_i;
      end
      default: ;
    endcase
  end

  // Payload shift register and bit index
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if ((state == ST_IDLE) && start_edge) begin
      bit_idx <= '0;
    end else if ((state == ST_DATA) && sample) begin
      shreg   <= {shreg[33:0], cmd_s};
      bit_idx <= bit_idx + 6'd1;
    end
  end

  // Held copy of the last accepted record
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      id_q  <= '0;
      buf_q <= '0;
      ok_q  <= 1'b0;
    end else if (emit_acc) begin
      id_q  <= sr_id;
      buf_q <= sr_buf;
      ok_q  <= sr_ok;
    end
  end

  // Saturating error and drop counters
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      frame_err_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (stop_err && (frame_err_q != 8'hFF)) frame_err_q <= frame_err_q + 8'd1;
      if (emit_drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  // The new record is passed straight through during the strobe cycle so the
  // FIFO captures it together with event_wr_o; afterwards the held copy shows.
  assign bus.event_wr_o     = emit_acc;
  assign bus.digitize_o     = emit_acc ? (4'b0001 << sr_buf) : 4'b0000;
  assign bus.event_id_o     = emit_acc ? sr_id  : id_q;
  assign bus.event_buffer_o = emit_acc ? sr_buf : buf_q;
  assign bus.event_id_ok_o  = emit_acc ? sr_ok  : ok_q;
  assign bus.frame_err_o    = frame_err_q;
  assign bus.drop_cnt_o     = drop_cnt_q;
  assign bus.busy_o         = (state != ST_IDLE);

endmodule
